// File: rtl/fir_pkg.sv
// Shared constants, types, coefficient table and the round/saturate helper
// for the 32-tap low-pass FIR that feeds the FFT input stage.
package fir_pkg;

  localparam int TAPS   = 32;
  localparam int DATA_W = 16;
  localparam int COEF_W = 20;
  localparam int ACC_W  = 41;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Symmetric Q4.16 low-pass taps; the sum is exactly 0x10000 so DC passes at unity gain.
  localparam coef_t COEF [TAPS] = '{
    -20'sd40,   -20'sd60,   -20'sd50,   20'sd0,
     20'sd200,   20'sd500,   20'sd900,  20'sd1400,
     20'sd2000,  20'sd2600,  20'sd3200, 20'sd3700,
     20'sd4100,  20'sd4400,  20'sd4600, 20'sd5318,
     20'sd5318,  20'sd4600,  20'sd4400, 20'sd4100,
     20'sd3700,  20'sd3200,  20'sd2600, 20'sd2000,
     20'sd1400,  20'sd900,   20'sd500,  20'sd200,
     20'sd0,    -20'sd50,   -20'sd60,  -20'sd40
  };

  localparam logic signed [ACC_W:0] WIDE_MAX = (ACC_W+1)'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W:0] WIDE_MIN = (ACC_W+1)'(-(2**(DATA_W-1)));

  // Round half up, arithmetic shift right, clamp to the signed sample range.
  function automatic sample_t sat_round(input acc_t acc, input int shift);
    logic signed [ACC_W:0] wide;
    wide = {acc[ACC_W-1], acc};
    wide = wide + ((ACC_W+1)'(1) << (shift - 1));
    wide = wide >>> shift;
    if (wide > WIDE_MAX) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (wide < WIDE_MIN) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end
    return wide[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_if.sv
// Sample stream into the FIR and filtered stream out toward the FFT.
interface fir_if #(
  parameter int DATA_W = fir_pkg::DATA_W
);
  logic                     data_valid;
  logic signed [DATA_W-1:0] data;
  logic                     fir_valid;
  logic signed [DATA_W-1:0] fir_d;

  modport master (
    output data_valid,
    output data,
    input  fir_valid,
    input  fir_d
  );

  modport slave (
    input  data_valid,
    input  data,
    output fir_valid,
    output fir_d
  );
endinterface

// File: rtl/fir_sat_round.sv
// Combinational round, shift and saturate from the wide accumulator to a sample.
module fir_sat_round
  import fir_pkg::*;
#(
  parameter int OUT_SHIFT = 16
) (
  input  acc_t    acc,
  output sample_t y
);
  always_comb y = sat_round(acc, OUT_SHIFT);
endmodule

// File: rtl/fir_filter.sv
// Streaming direct-form FIR: delay line, registered multiplier bank, then
// adder tree + round/saturate into the output register, one sample per clock.
module fir_filter #(
  parameter int TAPS      = fir_pkg::TAPS,
  parameter int DATA_W    = fir_pkg::DATA_W,
  parameter int COEF_W    = fir_pkg::COEF_W,
  parameter int OUT_SHIFT = 16
) (
  input  logic clk,
  input  logic rst,
  fir_if.slave bus
);
  import fir_pkg::*;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(TAPS + 1);

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  data_t            x_q [TAPS];
  data_t            x_d [TAPS];
  logic [CNT_W-1:0] count_q, count_d;
  logic             v1_q, v1_d;
  prod_t            p_q [TAPS];
  prod_t            p_d [TAPS];
  logic             v2_q, v2_d;
  acc_t             acc;
  data_t            y_sat;
  data_t            fir_d_q, fir_d_d;
  logic             fir_valid_q, fir_valid_d;

  // S1: delay line shifts only on accepted samples; the warm-up counter
  // saturates at TAPS so v1 marks every sample that completes a full window.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    x_d     = x_q;
    count_d = count_q;
    v1_d    = 1'b0;
    if (bus.data_valid) begin
      x_d[0] = bus.data;
      for (int k = 1; k < TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
      if (count_q != CNT_W'(TAPS)) begin
        count_d = count_q + CNT_W'(1);
      end
      v1_d = (count_q >= CNT_W'(TAPS - 1));
    end
  end

  // S2: full-precision products of each tap.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      p_d[k] = prod_t'(x_q[k]) * prod_t'(COEF[k]);
    end
    v2_d = v1_q;
  end

  // S3: sum the products; fir_d only moves when a valid result lands.
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc = acc + acc_t'(p_q[k]);
    end
    fir_valid_d = v2_q;
    fir_d_d     = v2_q ? data_t'(y_sat) : fir_d_q;
  end

  fir_sat_round #(
    .OUT_SHIFT(OUT_SHIFT)
  ) u_sat_round (
    .acc(acc),
    .y  (y_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '{default: '0};
      count_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      fir_valid_q <= 1'b0;
      fir_d_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of its neighbours.
      x_q         <= x_d;
      count_q     <= count_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      fir_valid_q <= fir_valid_d;
      fir_d_q     <= fir_d_d;
    end
  end

  // NOTE: the product bank has no reset; it is only observed when v2_q is set, which reset clears.
  always_ff @(posedge clk) begin
    p_q <= p_d;
  end

  assign bus.fir_valid = fir_valid_q;
  assign bus.fir_d     = fir_d_q;

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: table-driven streams scored against a
// queue of expected outputs tagged with the cycle they must appear in.
module tb_fir_filter;
  import fir_pkg::*;

  typedef logic signed [15:0] smp_t;

  typedef struct {
    logic vld;
    smp_t d;
    smp_t exp_d;
  } vec_t;

  typedef struct {
    smp_t d;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_if #(.DATA_W(DATA_W)) dut_if ();
  fir_if #(.DATA_W(DATA_W)) sat_if ();

  fir_filter #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_SHIFT(16)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(dut_if.slave)
  );

  fir_filter #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_SHIFT(14)
  ) u_sat (
    .clk(clk), .rst(rst), .bus(sat_if.slave)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     n_valid  = 0;
  longint frame_sum = 0;
  exp_t   sb[$];
  smp_t   hist [TAPS];
  int     win = 0;

  vec_t imp_vec [63];
  vec_t dc_vec  [40];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: an entry must appear exactly in its due cycle; otherwise the output stays idle.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        check("out_valid", dut_if.fir_valid, 1);
        check("out_data", dut_if.fir_d, sb[0].d);
        void'(sb.pop_front());
      end else begin
        check("idle_valid", dut_if.fir_valid, 0);
      end
      if (dut_if.fir_valid) begin
        n_valid++;
        frame_sum += longint'(dut_if.fir_d);
      end
    end
  end

  function automatic smp_t model_y(input int shift);
    longint acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(hist[k]) * longint'(COEF[k]);
    acc = (acc + (longint'(1) << (shift - 1))) >>> shift;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return smp_t'(acc);
  endfunction

  // Drive one cycle of input; a sample that completes a window is due 3 edges later.
  task automatic send(input logic vld, input smp_t d, input smp_t exp_d, input bit use_model);
    exp_t e;
    @(posedge clk);
    #1;
    dut_if.data_valid = vld;
    dut_if.data       = d;
    if (vld) begin
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      if (win < TAPS) win++;
      if (win == TAPS) begin
        e.d   = use_model ? model_y(16) : exp_d;
        e.due = cyc + 3;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string tag);
    repeat (6) send(1'b0, '0, '0, 1'b0);
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    dut_if.data_valid = 1'b0;
    sat_if.data_valid = 1'b0;
    sb.delete();
    win = 0;
    for (int k = 0; k < TAPS; k++) hist[k] = '0;
    #1;
    check({tag, "_rst_valid"}, dut_if.fir_valid, 0);
    check({tag, "_rst_d"}, dut_if.fir_d, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic sat_run(input string tag, input smp_t v, input smp_t exp_d);
    do_reset(tag);
    for (int i = 0; i < 37; i++) begin
      @(posedge clk);
      #1;
      sat_if.data_valid = 1'b1;
      sat_if.data       = v;
      @(negedge clk);
      check({tag, "_valid"}, sat_if.fir_valid, (i >= 34));
      if (i >= 34) check({tag, "_d"}, sat_if.fir_d, exp_d);
    end
    @(posedge clk);
    #1;
    sat_if.data_valid = 1'b0;
  endtask

  initial begin
    int imp_half [16] = '{0, 0, 0, 0, 1, 2, 4, 5, 8, 10, 13, 14, 16, 17, 18, 21};

    for (int i = 0; i < 63; i++) begin
      imp_vec[i].vld   = 1'b1;
      imp_vec[i].d     = (i == 31) ? 16'sh0100 : 16'sh0000;
      imp_vec[i].exp_d = (i >= 31) ? smp_t'(imp_half[(i - 31) < 16 ? (i - 31) : (62 - i)]) : '0;
    end
    for (int i = 0; i < 40; i++) dc_vec[i] = '{1'b1, 16'sh0100, 16'sh0100};

    rst = 1'b1;
    dut_if.data_valid = 1'b0;
    dut_if.data       = '0;
    sat_if.data_valid = 1'b0;
    sat_if.data       = '0;
    for (int k = 0; k < TAPS; k++) hist[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("por_valid", dut_if.fir_valid, 0);
    check("por_d", dut_if.fir_d, 0);
    #2;
    rst = 1'b0;

    // Impulse: outputs walk the rounded coefficient table.
    n_valid = 0;
    for (int i = 0; i < 63; i++) send(imp_vec[i].vld, imp_vec[i].d, imp_vec[i].exp_d, 1'b0);
    drain("impulse");
    check("impulse_count", n_valid, 32);

    // DC warm-up: 40 samples give 9 outputs at unity gain.
    do_reset("dc");
    n_valid = 0;
    for (int i = 0; i < 40; i++) send(dc_vec[i].vld, dc_vec[i].d, dc_vec[i].exp_d, 1'b0);
    drain("dc");
    check("dc_count", n_valid, 9);

    // Two-cycle input gap shows up as a two-cycle output gap.
    do_reset("gap");
    n_valid = 0;
    for (int i = 0; i < 32; i++) send(1'b1, 16'sh0200, 16'sh0200, 1'b0);
    repeat (2) send(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 16; i++) send(1'b1, 16'sh0200, 16'sh0200, 1'b0);
    drain("gap");
    check("gap_count", n_valid, 17);
    check("gap_hold_d", dut_if.fir_d, 16'sh0200);

    // Reset while outputs are streaming, then a fresh warm-up.
    for (int i = 0; i < 20; i++) send(1'b1, 16'sh0200, 16'sh0200, 1'b0);
    check("midrst_pre_valid", dut_if.fir_valid, 1);
    do_reset("midrst");
    n_valid = 0;
    for (int i = 0; i < 40; i++) send(dc_vec[i].vld, dc_vec[i].d, dc_vec[i].exp_d, 1'b0);
    drain("midrst");
    check("midrst_count", n_valid, 9);

    // Saturation at OUT_SHIFT = 14.
    sat_run("sat_pos", 16'sh4000, 16'sh7FFF);
    sat_run("sat_neg", -16'sh4000, -16'sh8000);

    // One FFT frame: 47 DC samples give 16 contiguous outputs, DC bin 16 * 0x0100.
    do_reset("fft");
    n_valid   = 0;
    frame_sum = 0;
    for (int i = 0; i < 47; i++) send(1'b1, 16'sh0100, 16'sh0100, 1'b0);
    drain("fft");
    check("fft_count", n_valid, 16);
    check("fft_dc_bin", frame_sum, 4096);

    // Random data with random gaps against the arithmetic model.
    do_reset("rand");
    for (int i = 0; i < 80; i++) begin
      send(($urandom_range(0, 9) != 0), smp_t'($urandom), '0, 1'b1);
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
